// File: rtl/ssd_display_driver.sv
// Converts a 13-bit binary value to four BCD digits with a sequential double-dabble
// engine, then time-multiplexes them onto a 4-digit common-anode seven-segment display.
module ssd_display_driver #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        busy
);

    localparam int unsigned      CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       ITER_LAST = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [12:0]      last_val;
    logic [12:0]      bin_sr;
    logic [12:0]      bin_nxt;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_nxt;
    logic [15:0]      digits;
    logic [3:0]       iter;
    logic             changed;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       sel;
    logic [3:0]       cur_digit;
    logic             cur_blank;
    logic             blank3;
    logic             blank2;
    logic             blank1;
    logic [3:0]       anode_nxt;
    logic [6:0]       seg_nxt;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = '1;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = '1;
        endcase
        return s;
    endfunction

    assign changed = (value != last_val);

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (changed) begin
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                busy = 1'b1;
                if (iter == ITER_LAST) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One double-dabble step: correct each nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_sr} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_val <= '0;
            bin_sr   <= '0;
            bcd      <= '0;
            iter     <= '0;
            digits   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (changed) begin
                        bin_sr   <= value;
                        last_val <= value;
                        bcd      <= '0;
                        iter     <= '0;
                    end
                end
                CONVERT: begin
                    bcd    <= bcd_nxt;
                    bin_sr <= bin_nxt;
                    iter   <= iter + 4'd1;
                end
                LOAD: begin
                    digits <= bcd;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- display multiplexing ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            sel         <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            sel         <= sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A digit above the ones place is blank only if it and all higher digits are zero.
    always_comb begin
        blank3    = BLANK_LEADING && (digits[15:12] == 4'd0);
        blank2    = blank3 && (digits[11:8] == 4'd0);
        blank1    = blank2 && (digits[7:4] == 4'd0);
        cur_digit = digits[3:0];
        cur_blank = 1'b0;
        unique case (sel)
            2'd0: begin
                cur_digit = digits[3:0];
                cur_blank = 1'b0;
            end
            2'd1: begin
                cur_digit = digits[7:4];
                cur_blank = blank1;
            end
            2'd2: begin
                cur_digit = digits[11:8];
                cur_blank = blank2;
            end
            2'd3: begin
                cur_digit = digits[15:12];
                cur_blank = blank3;
            end
            default: begin
            end
        endcase
        anode_nxt = ~(4'b0001 << sel);
        seg_nxt   = cur_blank ? 7'b1111111 : seg_decode(cur_digit);
    end

    // Anode and segments share one register stage so a digit never shows on the wrong anode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode    <= '1;
            segments <= '1;
        end else begin
            anode    <= anode_nxt;
            segments <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Scoreboard bench for ssd_display_driver: two instances (fast refresh with leading
// blanking, faster refresh without) share stimulus; monitors pop expected scans and busy pulses.
module tb_ssd_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } scan_t;

    typedef struct {
        int len;
        int gap;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic [3:0]  anode1;
    logic [6:0]  segs1;
    logic        busy1;
    logic [3:0]  anode2;
    logic [6:0]  segs2;
    logic        busy2;

    int errors = 0;
    int checks = 0;

    scan_t  q1[$];
    scan_t  q2[$];
    pulse_t bq[$];

    ssd_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u1 (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode1), .segments(segs1), .busy(busy1)
    );

    ssd_display_driver #(.REFRESH_DIV(2), .BLANK_LEADING(1'b0)) u2 (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode2), .segments(segs2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_scan(input int which, input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
        scan_t e[4];
        e[0] = '{4'b1110, d0};
        e[1] = '{4'b1101, d1};
        e[2] = '{4'b1011, d2};
        e[3] = '{4'b0111, d3};
        for (int i = 0; i < 4; i++) begin
            if (which == 1) q1.push_back(e[i]);
            else            q2.push_back(e[i]);
        end
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("scan_complete", (q1.size() == 0 && q2.size() == 0) ? 1 : 0, 1);
        q1.delete();
        q2.delete();
    endtask

    task automatic wait_busy_fall(input int bound);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (busy1)     seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk("busy_fall_seen", int'(done), 1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    // Scan monitor, instance 1 (REFRESH_DIV=4)
    logic [3:0] m1_prev = 4'hf;
    int         m1_len  = 0;
    int         m1_idx;
    always @(negedge clk) begin
        if (!rst) begin
            m1_prev = 4'hf;
            m1_len  = 0;
        end else if (anode1 != m1_prev) begin
            if (q1.size() > 0) begin
                if (m1_prev != 4'hf) begin
                    chk("u1_anode_order", int'(anode1), int'({m1_prev[2:0], m1_prev[3]}));
                    chk("u1_slot_len", m1_len, 4);
                end
                m1_idx = -1;
                for (int i = 0; i < q1.size(); i++)
                    if (m1_idx < 0 && q1[i].an == anode1) m1_idx = i;
                if (m1_idx >= 0) begin
                    chk($sformatf("u1_segments_an%b", anode1), int'(segs1), int'(q1[m1_idx].seg));
                    q1.delete(m1_idx);
                end
            end
            m1_prev = anode1;
            m1_len  = 1;
        end else begin
            m1_len++;
        end
    end

    // Scan monitor, instance 2 (REFRESH_DIV=2)
    logic [3:0] m2_prev = 4'hf;
    int         m2_len  = 0;
    int         m2_idx;
    always @(negedge clk) begin
        if (!rst) begin
            m2_prev = 4'hf;
            m2_len  = 0;
        end else if (anode2 != m2_prev) begin
            if (q2.size() > 0) begin
                if (m2_prev != 4'hf) begin
                    chk("u2_anode_order", int'(anode2), int'({m2_prev[2:0], m2_prev[3]}));
                    chk("u2_slot_len", m2_len, 2);
                end
                m2_idx = -1;
                for (int i = 0; i < q2.size(); i++)
                    if (m2_idx < 0 && q2[i].an == anode2) m2_idx = i;
                if (m2_idx >= 0) begin
                    chk($sformatf("u2_segments_an%b", anode2), int'(segs2), int'(q2[m2_idx].seg));
                    q2.delete(m2_idx);
                end
            end
            m2_prev = anode2;
            m2_len  = 1;
        end else begin
            m2_len++;
        end
    end

    // Busy pulse monitor: pulse width and preceding idle gap
    int     b_hi  = 0;
    int     b_lo  = 0;
    int     b_gap = 0;
    pulse_t b_exp;
    always @(negedge clk) begin
        if (!rst) begin
            b_hi = 0;
            b_lo = 0;
        end else if (busy1) begin
            if (b_hi == 0) b_gap = b_lo;
            b_hi++;
        end else begin
            if (b_hi > 0) begin
                if (bq.size() == 0) begin
                    chk("busy_unexpected_pulse", 1, 0);
                end else begin
                    b_exp = bq.pop_front();
                    chk("busy_len", b_hi, b_exp.len);
                    if (b_exp.gap >= 0) chk("busy_gap", b_gap, b_exp.gap);
                end
                b_hi = 0;
                b_lo = 0;
            end
            b_lo++;
        end
    end

    initial begin
        rst   = 1'b0;
        value = 13'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_anode1", int'(anode1), 4'hf);
        chk("rst_segs1", int'(segs1), 7'h7f);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_anode2", int'(anode2), 4'hf);
        chk("rst_segs2", int'(segs2), 7'h7f);

        // Idle after reset: 0 displayed, no conversion; u2 runs two full scans across the wrap
        rst = 1'b1;
        push_scan(1, S0, SB, SB, SB);
        push_scan(2, S0, S0, S0, S0);
        push_scan(2, S0, S0, S0, S0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_busy", int'(busy1), 0);
        end
        wait_empty(60);

        // 1234
        bq.push_back('{14, -1});
        value = 13'd1234;
        wait_busy_fall(40);
        settle();
        push_scan(1, S4, S3, S2, S1);
        push_scan(2, S4, S3, S2, S1);
        wait_empty(60);

        // 8191
        bq.push_back('{14, -1});
        value = 13'd8191;
        wait_busy_fall(40);
        settle();
        push_scan(1, S1, S9, S1, S8);
        push_scan(2, S1, S9, S1, S8);
        wait_empty(60);

        // 7: leading blanking on u1 only
        bq.push_back('{14, -1});
        value = 13'd7;
        wait_busy_fall(40);
        settle();
        push_scan(1, S7, SB, SB, SB);
        push_scan(2, S7, S0, S0, S0);
        wait_empty(60);

        // 42 -> 99 on the 5th CONVERT cycle
        bq.push_back('{14, -1});
        bq.push_back('{14, 1});
        value = 13'd42;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        value = 13'd99;
        wait_busy_fall(40);
        settle();
        push_scan(2, S2, S4, S0, S0);
        wait_empty(12);
        wait_busy_fall(40);
        settle();
        push_scan(1, S9, S9, SB, SB);
        push_scan(2, S9, S9, S0, S0);
        wait_empty(60);

        // Reset during CONVERT of 5000
        bq.push_back('{14, -1});
        value = 13'd5000;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_anode1", int'(anode1), 4'hf);
        chk("midrst_segs1", int'(segs1), 7'h7f);
        chk("midrst_busy1", int'(busy1), 0);
        chk("midrst_anode2", int'(anode2), 4'hf);
        chk("midrst_segs2", int'(segs2), 7'h7f);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_busy_fall(40);
        settle();
        push_scan(1, S0, S0, S0, S5);
        push_scan(2, S0, S0, S0, S5);
        wait_empty(60);

        repeat (20) @(negedge clk);
        chk("busy_pulses_outstanding", bq.size(), 0);
        chk("final_busy", int'(busy1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
